// File: rtl/poly_synth_core.sv
`default_nettype none
// ============================================================================
//  Module   : poly_synth_core
//  Purpose  : NUM_VOICES time-multiplexed oscillator voices, each with a
//             phase accumulator, waveform select and attack/sustain/release
//             envelope. Voices are mixed with saturation into one signed
//             sample per sample_tick.
//  Options  : define SYNTH_SINE_EN to build the quarter-wave sine ROM used by
//             wave select 11 (otherwise wave 11 is silent).
//  Revision : 1.0  initial release
// ============================================================================
module poly_synth_core #(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 24,
    parameter int SAMPLE_W   = 16,
    parameter int ENV_W      = 8,
    parameter int ATK_STEP   = 16,
    parameter int REL_STEP   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sample_tick,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [$clog2(NUM_VOICES)-1:0] cmd_voice,
    input  logic [PHASE_W-1:0]            cmd_phase_inc,
    input  logic [1:0]                    cmd_wave,
    output logic [SAMPLE_W-1:0]           sample_out,
    output logic                          sample_valid,
    output logic [NUM_VOICES-1:0]         voice_active,
    output logic                          busy,
    output logic                          overrun
);
    localparam int c_vw = $clog2(NUM_VOICES);
    localparam int c_aw = SAMPLE_W + c_vw;          // mix accumulator width
    localparam int c_pw = SAMPLE_W + ENV_W + 1;     // wave * level product width
    localparam logic [ENV_W-1:0]           c_lvl_max = '1;
    localparam logic [ENV_W:0]             c_atk     = (ENV_W+1)'(ATK_STEP);
    localparam logic [ENV_W-1:0]           c_rel     = ENV_W'(REL_STEP);
    localparam logic signed [SAMPLE_W-1:0] c_max     = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SAMPLE_W-1:0] c_min     = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [1:0] c_op_on  = 2'b01;
    localparam logic [1:0] c_op_off = 2'b10;
    localparam logic [1:0] c_op_all = 2'b11;

    typedef enum logic [1:0] {S_WAIT, S_ACC, S_OUT} frame_state_t;
    typedef enum logic [1:0] {E_IDLE, E_ATTACK, E_SUSTAIN, E_RELEASE} env_state_t;

    frame_state_t            r_state;
    logic [c_vw-1:0]         r_slot;
    logic signed [c_aw-1:0]  r_acc;
    env_state_t              r_env   [NUM_VOICES];
    logic [ENV_W-1:0]        r_level [NUM_VOICES];
    logic [PHASE_W-1:0]      r_phase [NUM_VOICES];
    logic [PHASE_W-1:0]      r_inc   [NUM_VOICES];
    logic [1:0]              r_wave  [NUM_VOICES];

    env_state_t              w_env_cur;
    env_state_t              w_env_nxt;
    logic [ENV_W-1:0]        w_lvl_cur;
    logic [ENV_W-1:0]        w_lvl_nxt;
    logic [ENV_W:0]          w_lvl_sum;
    logic [PHASE_W-1:0]      w_ph;
    logic [1:0]              w_wave;
    logic [SAMPLE_W-1:0]     w_u_saw;
    logic [SAMPLE_W-1:0]     w_u_tri;
    logic signed [SAMPLE_W-1:0] w_wave_val;
    logic signed [SAMPLE_W-1:0] w_sine;
    logic signed [c_pw-1:0]  w_prod;
    logic signed [c_aw-1:0]  w_voice_val;
    logic signed [c_aw-1:0]  w_acc_nxt;
    logic signed [SAMPLE_W-1:0] w_sat;

    assign busy      = (r_state != S_WAIT);
    assign cmd_ready = ~busy;

    // Voice activity flags straight from the envelope states
    always_comb begin
        voice_active = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            voice_active[v] = (r_env[v] != E_IDLE);
        end
    end

    // Envelope step for the voice owning the current slot
    always_comb begin
        w_env_cur = r_env[r_slot];
        w_lvl_cur = r_level[r_slot];
        w_ph      = r_phase[r_slot];
        w_wave    = r_wave[r_slot];
        w_lvl_sum = {1'b0, w_lvl_cur} + c_atk;
        w_env_nxt = w_env_cur;
        w_lvl_nxt = w_lvl_cur;
        case (w_env_cur)
            E_ATTACK: begin
                if (w_lvl_sum >= {1'b0, c_lvl_max}) begin
                    w_lvl_nxt = c_lvl_max;
                    w_env_nxt = E_SUSTAIN;
                end else begin
                    w_lvl_nxt = w_lvl_sum[ENV_W-1:0];
                end
            end
            E_RELEASE: begin
                if (w_lvl_cur <= c_rel) begin
                    w_lvl_nxt = '0;
                    w_env_nxt = E_IDLE;
                end else begin
                    w_lvl_nxt = w_lvl_cur - c_rel;
                end
            end
            default: ;
        endcase
    end

`ifdef SYNTH_SINE_EN
    // Quarter sine in Q16 via an odd polynomial whose coefficients sum to
    // exactly 1.0, so entry 255 lands exactly on the positive peak.
    function automatic logic [SAMPLE_W-2:0] quarter_sine(input int idx);
        longint x1, x3, x5, p;
        x1 = longint'(idx);
        x3 = x1 * x1 * x1;
        x5 = x3 * x1 * x1;
        p  = (64'sd102936 * x1) / 64'sd255
           - (64'sd42252 * x3) / 64'sd16581375
           + (64'sd4852 * x5) / 64'sd1078203909375;
        quarter_sine = (SAMPLE_W-1)'((longint'(c_max) * p + 64'sd32768) >>> 16);
    endfunction

    logic [SAMPLE_W-2:0] w_rom [256];
    logic [7:0]          w_sidx;
    logic [SAMPLE_W-2:0] w_smag;

    for (genvar gi = 0; gi < 256; gi++) begin : g_rom
        assign w_rom[gi] = quarter_sine(gi);
    end

    // Quadrant fold: bit PHASE_W-2 mirrors the index, the MSB negates
    always_comb begin
        w_sidx = w_ph[PHASE_W-2] ? ~w_ph[PHASE_W-3 -: 8] : w_ph[PHASE_W-3 -: 8];
        w_smag = w_rom[w_sidx];
        w_sine = w_ph[PHASE_W-1] ? -$signed({1'b0, w_smag}) : $signed({1'b0, w_smag});
    end
`else
    assign w_sine = '0;
`endif

    // Waveform, envelope scaling, mix and saturation for the current slot
    always_comb begin
        w_u_saw    = w_ph[PHASE_W-1 -: SAMPLE_W];
        w_u_tri    = w_ph[PHASE_W-2 -: SAMPLE_W];
        w_wave_val = '0;
        case (w_wave)
            2'b00:   w_wave_val = w_ph[PHASE_W-1] ? -c_max : c_max;
            // u - 2^(SAMPLE_W-1) is just an MSB flip in two's complement
            2'b01:   w_wave_val = $signed(w_u_saw ^ c_min);
            2'b10:   w_wave_val = w_ph[PHASE_W-1] ? $signed(c_max - w_u_tri)
                                                  : $signed(w_u_tri ^ c_min);
            default: w_wave_val = w_sine;
        endcase
        w_prod      = c_pw'(w_wave_val) * c_pw'($signed({1'b0, w_lvl_nxt}));
        w_voice_val = (w_env_cur == E_IDLE) ? '0 : c_aw'(w_prod >>> ENV_W);
        w_acc_nxt   = r_acc + w_voice_val;
        if (w_acc_nxt > c_aw'(c_max)) begin
            w_sat = c_max;
        end else if (w_acc_nxt < c_aw'(c_min)) begin
            w_sat = c_min;
        end else begin
            w_sat = w_acc_nxt[SAMPLE_W-1:0];
        end
    end

    // Frame sequencer, command handling and per-voice state update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_WAIT;
            r_slot       <= '0;
            r_acc        <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_env[v]   <= E_IDLE;
                r_level[v] <= '0;
                r_phase[v] <= '0;
                r_inc[v]   <= '0;
                r_wave[v]  <= 2'b00;
            end
        end else begin
            sample_valid <= 1'b0;
            case (r_state)
                S_WAIT: begin
                    // Commands land before the frame a same-cycle tick starts
                    if (cmd_valid) begin
                        case (cmd_op)
                            c_op_on: begin
                                r_inc[cmd_voice]   <= cmd_phase_inc;
                                r_wave[cmd_voice]  <= cmd_wave;
                                r_phase[cmd_voice] <= '0;
                                r_env[cmd_voice]   <= E_ATTACK;
                            end
                            c_op_off: begin
                                if (r_env[cmd_voice] == E_ATTACK || r_env[cmd_voice] == E_SUSTAIN) begin
                                    r_env[cmd_voice] <= E_RELEASE;
                                end
                            end
                            c_op_all: begin
                                for (int v = 0; v < NUM_VOICES; v++) begin
                                    if (r_env[v] == E_ATTACK || r_env[v] == E_SUSTAIN) begin
                                        r_env[v] <= E_RELEASE;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                    if (sample_tick) begin
                        r_state <= S_ACC;
                        r_slot  <= '0;
                    end
                end
                S_ACC: begin
                    r_env[r_slot]   <= w_env_nxt;
                    r_level[r_slot] <= w_lvl_nxt;
                    if (w_env_cur != E_IDLE) begin
                        r_phase[r_slot] <= w_ph + r_inc[r_slot];
                    end
                    // The saturated mix is registered on the last slot so the
                    // sample is presented together with the S_OUT cycle.
                    if (r_slot == c_vw'(NUM_VOICES-1)) begin
                        sample_out   <= w_sat;
                        sample_valid <= 1'b1;
                        r_acc        <= '0;
                        r_state      <= S_OUT;
                    end else begin
                        r_acc  <= w_acc_nxt;
                        r_slot <= r_slot + c_vw'(1);
                    end
                    if (sample_tick) overrun <= 1'b1;
                end
                S_OUT: begin
                    r_state <= S_WAIT;
                    if (sample_tick) overrun <= 1'b1;
                end
                default: r_state <= S_WAIT;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_poly_synth_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_poly_synth_core
//  Purpose  : Directed self-checking bench for poly_synth_core (4 voices).
//  Revision : 1.0  initial release
// ============================================================================
module tb_poly_synth_core;
    localparam int N = 4;
`ifdef SYNTH_SINE_EN
    localparam bit SINE = 1'b1;
`else
    localparam bit SINE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_tick = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [1:0]  cmd_voice = 2'b00;
    logic [23:0] cmd_phase_inc = '0;
    logic [1:0]  cmd_wave = 2'b00;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic [3:0]  voice_active;
    logic        busy;
    logic        overrun;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    poly_synth_core dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_tick   (sample_tick),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_voice     (cmd_voice),
        .cmd_phase_inc (cmd_phase_inc),
        .cmd_wave      (cmd_wave),
        .sample_out    (sample_out),
        .sample_valid  (sample_valid),
        .voice_active  (voice_active),
        .busy          (busy),
        .overrun       (overrun)
    );

    task automatic check_val(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [1:0] v,
                            input logic [23:0] inc, input logic [1:0] w);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_voice = v; cmd_phase_inc = inc; cmd_wave = w;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Called #1 after the edge that captured the tick; waits for the sample
    task automatic collect(output logic signed [31:0] s);
        int k;
        k = 1;
        while (!sample_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check_val("latency", k, N + 1);
        s = $signed(sample_out);
        @(posedge clk); #1;
    endtask

    task automatic run_frame(output logic signed [31:0] s);
        @(negedge clk);
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        collect(s);
    endtask

    initial begin
        logic signed [31:0] s;
        int lvl, sgn, pulses, acc_edge, sv_seen;
        logic prev_rdy;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_ready", cmd_ready, 1);
        check_val("rst_sample", sample_out, 0);
        check_val("rst_valid", sample_valid, 0);
        check_val("rst_active", voice_active, 0);
        check_val("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Attack of a single square voice
        send_cmd(2'b01, 2'd0, 24'h080000, 2'b00);
        for (int k = 1; k <= 20; k++) begin
            run_frame(s);
            lvl = (16 * k > 255) ? 255 : 16 * k;
            sgn = (k <= 16) ? 1 : -1;
            check_val($sformatf("atk_f%0d", k), s, (sgn * 32767 * lvl) >>> 8);
        end
        check_val("atk_active", voice_active, 4'b0001);

        // Release of the sustained voice
        send_cmd(2'b10, 2'd0, 24'h0, 2'b00);
        for (int k = 1; k <= 32; k++) begin
            run_frame(s);
            lvl = (k <= 31) ? 255 - 8 * k : 0;
            sgn = (((19 + k) % 32) >= 16) ? -1 : 1;
            check_val($sformatf("rel_f%0d", k), s, (sgn * 32767 * lvl) >>> 8);
            check_val($sformatf("rel_act%0d", k), voice_active[0], (k < 32) ? 1 : 0);
        end

        // Four voices in phase saturate both ways
        for (int v = 0; v < 4; v++) send_cmd(2'b01, 2'(v), 24'h080000, 2'b00);
        for (int k = 1; k <= 17; k++) begin
            run_frame(s);
            if (k == 16) check_val("sat_pos", s, 32767);
            if (k == 17) check_val("sat_neg", s, -32768);
        end
        check_val("all_active", voice_active, 4'hF);

        // ALL_OFF releases every voice
        send_cmd(2'b11, 2'd0, 24'h0, 2'b00);
        run_frame(s);
        check_val("alloff_f1", s, -32768);
        check_val("alloff_act", voice_active, 4'hF);
        for (int k = 2; k <= 32; k++) run_frame(s);
        check_val("alloff_f32", s, 0);
        check_val("alloff_idle", voice_active, 4'h0);

        // Tick while busy, command held through the frame
        @(negedge clk);
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        @(negedge clk);
        sample_tick = 1'b1;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_voice = 2'd2; cmd_phase_inc = 24'h080000; cmd_wave = 2'b00;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        check_val("ready_busy", cmd_ready, 0);
        check_val("overrun", overrun, 1);
        pulses = 0; acc_edge = 0; prev_rdy = cmd_ready;
        for (int e = 2; e <= 20; e++) begin
            @(posedge clk); #1;
            if (sample_valid) pulses++;
            if (prev_rdy && cmd_valid) begin
                cmd_valid = 1'b0;
                acc_edge = e;
            end
            prev_rdy = cmd_ready;
        end
        check_val("one_frame", pulses, 1);
        check_val("accept_edge", acc_edge, 6);
        check_val("v2_active", voice_active, 4'b0100);

        // NOTE_ON and tick in the same cycle: voice 3 is heard in that frame
        @(negedge clk);
        sample_tick = 1'b1;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_voice = 2'd3; cmd_phase_inc = 24'h080000; cmd_wave = 2'b00;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        cmd_valid = 1'b0;
        collect(s);
        check_val("same_cycle", s, 4094);
        check_val("same_active", voice_active, 4'b1100);

        // Quiet everything, then a sine voice
        send_cmd(2'b11, 2'd0, 24'h0, 2'b00);
        run_frame(s);
        run_frame(s);
        check_val("quiet", voice_active, 4'h0);
        send_cmd(2'b01, 2'd1, 24'h400000, 2'b11);
        for (int k = 1; k <= 18; k++) begin
            run_frame(s);
            if (k == 16) check_val("sine_trough", s, SINE ? -32640 : 0);
            if (k == 18) check_val("sine_peak", s, SINE ? 32639 : 0);
        end
        check_val("sine_active", voice_active, 4'b0010);

        // Asynchronous reset in the middle of a frame
        send_cmd(2'b01, 2'd0, 24'h080000, 2'b00);
        run_frame(s);
        check_val("pre_rst", s, 2047);
        @(negedge clk);
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_sample", sample_out, 0);
        check_val("arst_valid", sample_valid, 0);
        check_val("arst_active", voice_active, 0);
        check_val("arst_busy", busy, 0);
        check_val("arst_ready", cmd_ready, 1);
        check_val("arst_overrun", overrun, 0);
        sv_seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (sample_valid) sv_seen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            if (sample_valid) sv_seen++;
        end
        check_val("no_valid_after_rst", sv_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
